// File: rtl/alu_pkg.sv
// Shared definitions for the registered 8-bit ALU: data width, opcode
// encoding and the bundle of values the datapath hands to the output stage.
package alu_pkg;

    localparam int DATA_W = 8;
    localparam int SHAMT_W = 3;

    typedef enum logic [2:0] {
        OP_ADD  = 3'b000,
        OP_SUB  = 3'b001,
        OP_AND  = 3'b010,
        OP_OR   = 3'b011,
        OP_XOR  = 3'b100,
        OP_XNOR = 3'b101,
        OP_SHL  = 3'b110,
        OP_SHR  = 3'b111
    } op_e;

    typedef struct packed {
        logic [DATA_W-1:0] result;
        logic              zero;
        logic              carry;
    } alu_res_t;

    // Turn the raw 3-bit select field into the opcode type. Every encoding
    // is a legal operation, so this is a plain cast.
    function automatic op_e decode_op(input logic [2:0] sel);
        return op_e'(sel);
    endfunction

endpackage

// File: rtl/alu_core.sv
// Purely combinational ALU datapath: result, zero and carry from a, b, op.
module alu_core
    import alu_pkg::*;
(
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  op_e               op,
    output alu_res_t          res
);

    logic [DATA_W:0]    wide;
    logic [SHAMT_W-1:0] shamt;
    logic [DATA_W-1:0]  result;
    logic               carry;

    // Operation select. The 9-bit 'wide' value holds the extra bit that
    // becomes carry/borrow for arithmetic, and the last bit shifted out for
    // shifts: SHL pads a zero on the left so bit 8 ends up as a[8-n]; SHR
    // pads a zero on the right so bit 0 ends up as a[n-1]. With n=0 the pad
    // bit itself lands there, giving carry=0 with no special case.
    always_comb begin
        wide   = '0;
        result = '0;
        carry  = 1'b0;
        shamt  = b[SHAMT_W-1:0];
        case (op)
            OP_ADD: begin
                wide   = {1'b0, a} + {1'b0, b};
                result = wide[DATA_W-1:0];
                carry  = wide[DATA_W];
            end
            OP_SUB: begin
                wide   = {1'b0, a} - {1'b0, b};
                result = wide[DATA_W-1:0];
                carry  = wide[DATA_W];
            end
            OP_AND:  result = a & b;
            OP_OR:   result = a | b;
            OP_XOR:  result = a ^ b;
            OP_XNOR: result = ~(a ^ b);
            OP_SHL: begin
                wide   = {1'b0, a} << shamt;
                result = wide[DATA_W-1:0];
                carry  = wide[DATA_W];
            end
            OP_SHR: begin
                wide   = {a, 1'b0} >> shamt;
                result = wide[DATA_W:1];
                carry  = wide[0];
            end
            default: begin
                result = '0;
                carry  = 1'b0;
            end
        endcase
    end

    // Zero flag follows the 8-bit result for every operation.
    always_comb begin
        res.result = result;
        res.zero   = (result == '0);
        res.carry  = carry;
    end

endmodule

// File: rtl/alu.sv
// Registered ALU top: decodes select, feeds alu_core and registers the
// result, flags and valid.
//
// Handshake: in_valid has no ready partner; a transaction is accepted on
// every rising clk edge where in_valid=1 and rst=0, and its result appears
// with out_valid=1 after that same edge. out_valid is a single-cycle pulse
// per accepted transaction; out/zero/carry hold their last value otherwise.
module alu
    import alu_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  logic [2:0]        select,
    input  logic              in_valid,
    output logic [DATA_W-1:0] out,
    output logic              zero,
    output logic              carry,
    output logic              out_valid
);

    op_e      op;
    alu_res_t core_res;

    // Input decode of the operation code.
    always_comb begin
        op = decode_op(select);
    end

    alu_core u_core (
        .a   (a),
        .b   (b),
        .op  (op),
        .res (core_res)
    );

    // Output registers: load on accepted input, otherwise hold; valid pulses.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out       <= '0;
            zero      <= 1'b0;
            carry     <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            out_valid <= in_valid;
            if (in_valid) begin
                out   <= core_res.result;
                zero  <= core_res.zero;
                carry <= core_res.carry;
            end
        end
    end

endmodule

// File: tb/tb_alu.sv
// Directed testbench for the registered ALU.
module tb_alu;

    logic       clk;
    logic       rst;
    logic [7:0] a;
    logic [7:0] b;
    logic [2:0] select;
    logic       in_valid;
    logic [7:0] out;
    logic       zero;
    logic       carry;
    logic       out_valid;

    int checks = 0;
    int errors = 0;

    // expected {out, zero, carry}
    logic [9:0] exp_q[$];

    localparam logic [2:0] ADD  = 3'b000;
    localparam logic [2:0] SUB  = 3'b001;
    localparam logic [2:0] AND_ = 3'b010;
    localparam logic [2:0] OR_  = 3'b011;
    localparam logic [2:0] XOR_ = 3'b100;
    localparam logic [2:0] XNOR = 3'b101;
    localparam logic [2:0] SHL  = 3'b110;
    localparam logic [2:0] SHR  = 3'b111;

    alu dut (
        .clk       (clk),
        .rst       (rst),
        .a         (a),
        .b         (b),
        .select    (select),
        .in_valid  (in_valid),
        .out       (out),
        .zero      (zero),
        .carry     (carry),
        .out_valid (out_valid)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // driver: present one transaction and queue its hand-computed result
    task automatic drive(input logic [2:0] op, input logic [7:0] va, input logic [7:0] vb,
                         input logic [7:0] e_out, input logic e_zero, input logic e_carry);
        select   = op;
        a        = va;
        b        = vb;
        in_valid = 1'b1;
        exp_q.push_back({e_out, e_zero, e_carry});
    endtask

    // clock the pending transaction in and compare after the edge
    task automatic step_and_check(input string tag);
        logic [9:0] e;
        @(posedge clk);
        #1;
        e = exp_q.pop_front();
        check({tag, ".out"},   out,              e[9:2]);
        check({tag, ".zero"},  {7'd0, zero},     {7'd0, e[1]});
        check({tag, ".carry"}, {7'd0, carry},    {7'd0, e[0]});
        check({tag, ".valid"}, {7'd0, out_valid}, 8'd1);
    endtask

    task automatic idle();
        in_valid = 1'b0;
    endtask

    initial begin
        rst = 1'b1; a = 8'h00; b = 8'h00; select = 3'b000; in_valid = 1'b0;
        #3;
        check("rst.out",   out,              8'h00);
        check("rst.zero",  {7'd0, zero},     8'd0);
        check("rst.carry", {7'd0, carry},    8'd0);
        check("rst.valid", {7'd0, out_valid}, 8'd0);
        @(posedge clk); #1;
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
        check("idle.valid", {7'd0, out_valid}, 8'd0);

        // arithmetic
        drive(ADD, 8'd8,   8'd5,   8'd13,  1'b0, 1'b0); step_and_check("add_8_5");
        drive(ADD, 8'd200, 8'd100, 8'h2C,  1'b0, 1'b1); step_and_check("add_carry");
        drive(ADD, 8'hFF,  8'h01,  8'h00,  1'b1, 1'b1); step_and_check("add_wrap0");
        drive(SUB, 8'd10,  8'd10,  8'h00,  1'b1, 1'b0); step_and_check("sub_eq");
        drive(SUB, 8'd3,   8'd5,   8'hFE,  1'b0, 1'b1); step_and_check("sub_borrow");
        drive(SUB, 8'h00,  8'h01,  8'hFF,  1'b0, 1'b1); step_and_check("sub_0m1");

        // logical
        drive(AND_, 8'hAA, 8'hF0, 8'hA0, 1'b0, 1'b0); step_and_check("and");
        drive(OR_,  8'hAA, 8'hF5, 8'hFF, 1'b0, 1'b0); step_and_check("or");
        drive(XOR_, 8'h56, 8'h5C, 8'h0A, 1'b0, 1'b0); step_and_check("xor");
        drive(XNOR, 8'hAA, 8'hF0, 8'hA5, 1'b0, 1'b0); step_and_check("xnor");
        drive(XOR_, 8'h3C, 8'h3C, 8'h00, 1'b1, 1'b0); step_and_check("xor_zero");
        drive(AND_, 8'hFF, 8'hFF, 8'hFF, 1'b0, 1'b0); step_and_check("and_ff");

        // shifts (b[7:3] ignored)
        drive(SHL, 8'hAA, 8'hF5, 8'h40, 1'b0, 1'b1); step_and_check("shl_5");
        drive(SHR, 8'h81, 8'h01, 8'h40, 1'b0, 1'b1); step_and_check("shr_1");
        drive(SHL, 8'h81, 8'hF8, 8'h81, 1'b0, 1'b0); step_and_check("shl_0");
        drive(SHR, 8'h01, 8'h00, 8'h01, 1'b0, 1'b0); step_and_check("shr_0");
        drive(SHL, 8'h01, 8'h07, 8'h80, 1'b0, 1'b0); step_and_check("shl_7");
        drive(SHR, 8'h80, 8'h0F, 8'h01, 1'b0, 1'b0); step_and_check("shr_7");
        drive(SHL, 8'h80, 8'h01, 8'h00, 1'b1, 1'b1); step_and_check("shl_out0");

        // idle: outputs hold, operand changes ignored
        idle();
        a = 8'h12; b = 8'h34; select = ADD;
        @(posedge clk); #1;
        check("hold.valid", {7'd0, out_valid}, 8'd0);
        check("hold.out",   out,               8'h00);
        check("hold.zero",  {7'd0, zero},      8'd1);
        check("hold.carry", {7'd0, carry},     8'd1);
        a = 8'h99; b = 8'h01; select = SUB;
        @(posedge clk); #1;
        check("hold2.out",  out,               8'h00);

        // reset mid-stream
        drive(ADD, 8'd1, 8'd2, 8'd3, 1'b0, 1'b0); step_and_check("pre_rst");
        select = ADD; a = 8'd4; b = 8'd4; in_valid = 1'b1;
        #2;
        rst = 1'b1;
        #1;
        check("arst.out",   out,               8'h00);
        check("arst.zero",  {7'd0, zero},      8'd0);
        check("arst.carry", {7'd0, carry},     8'd0);
        check("arst.valid", {7'd0, out_valid}, 8'd0);
        @(posedge clk); #1;
        check("arst_edge.valid", {7'd0, out_valid}, 8'd0);
        check("arst_edge.out",   out,               8'h00);
        @(negedge clk);
        in_valid = 1'b0;
        rst = 1'b0;
        @(posedge clk); #1;
        check("post_rst.valid", {7'd0, out_valid}, 8'd0);
        check("post_rst.out",   out,               8'h00);

        // first result after release
        drive(ADD, 8'd4, 8'd4, 8'd8, 1'b0, 1'b0); step_and_check("first_after_rst");
        idle();
        @(posedge clk); #1;
        check("end.valid", {7'd0, out_valid}, 8'd0);
        check("end.out",   out,               8'd8);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // global time limit
    initial begin
        #100000;
        $display("FAIL timeout: observed running expected finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/alu.md
ALU -- requirements
Module: alu

Interface
REQ-001 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-002 The block SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-003 The block SHALL have port a, input, 8 bits: operand A, unsigned.
REQ-004 The block SHALL have port b, input, 8 bits: operand B, unsigned; for shifts, b[2:0] is the shift amount.
REQ-005 The block SHALL have port select, input, 3 bits: the operation code.
REQ-006 The block SHALL have port in_valid, input, 1 bit: the operands and select are sampled this cycle.
REQ-007 The block SHALL have port out, output, 8 bits: the registered result.
REQ-008 The block SHALL have port zero, output, 1 bit: registered; set when the result is 0x00.
REQ-009 The block SHALL have port carry, output, 1 bit: registered carry, borrow or shift-out flag.
REQ-010 The block SHALL have port out_valid, output, 1 bit: out, zero and carry hold a new result this cycle.

Function
REQ-011 The block SHALL decode select as follows:
- 000 ADD: a+b.
- 001 SUB: a-b, modulo 256.
- 010 AND: a&b.
- 011 OR: a|b.
- 100 XOR: a^b.
- 101 XNOR: ~(a^b).
- 110 SHL: a<<b[2:0], logical.
- 111 SHR: a>>b[2:0], logical.
REQ-012 For ADD, carry SHALL be bit 8 of the 9-bit sum.
REQ-013 For SUB, carry SHALL be the borrow: 1 iff a<b unsigned.
REQ-014 For SHL with n=b[2:0]>0, carry SHALL be a[8-n], the last bit shifted out; for n=0, carry SHALL be 0.
REQ-015 For SHR with n>0, carry SHALL be a[n-1]; for n=0, carry SHALL be 0.
REQ-016 For the logical ops AND, OR, XOR and XNOR, carry SHALL be 0.
REQ-017 zero SHALL be 1 iff the 8-bit result equals 0x00, for every operation.
REQ-018 Latency SHALL be 1 cycle: when in_valid=1 at edge N, out, zero, carry and out_valid=1 appear after edge N.
REQ-019 When in_valid=0 at an edge, out_valid SHALL be 0 after that edge, and out, zero and carry SHALL hold their previous values.
REQ-020 Back-to-back in_valid SHALL be accepted every cycle, with no stall and no backpressure.
REQ-021 b[7:3] SHALL be ignored for shift operations.
REQ-022 Operand changes while in_valid=0 SHALL NOT affect the outputs.

Reset
REQ-023 While rst=1, out SHALL be 0x00, zero=0, carry=0 and out_valid=0, immediately and without waiting for clk.
REQ-024 A transaction whose in_valid edge coincides with rst=1 SHALL be discarded.
REQ-025 The first result after rst deasserts SHALL appear one cycle after the first in_valid=1 edge.

Structure
REQ-026 A shared package alu_pkg SHALL hold the 3-bit opcode enum (OP_ADD .. OP_SHR) and the data-width constant (8).
REQ-027 The combinational datapath SHALL be one sub-module, alu_core, that computes result, zero and carry from a, b and select.
REQ-028 The top-level alu SHALL contain only the input decode and the output/valid registers around alu_core.

Verification
REQ-029 The bench SHALL apply ADD a=8, b=5 -> out=13, zero=0, carry=0, one cycle later.
REQ-030 The bench SHALL apply ADD a=200, b=100 -> out=0x2C, carry=1.
REQ-031 The bench SHALL apply SUB a=10, b=10 -> out=0, zero=1, carry=0.
REQ-032 The bench SHALL apply SUB a=3, b=5 -> out=0xFE, carry=1.
REQ-033 The bench SHALL apply the logical ops and check:
- AND a=0xAA, b=0xF0 -> 0xA0.
- OR a=0xAA, b=0xF5 -> 0xFF.
- XOR a=0x56, b=0x5C -> 0x0A.
- XNOR a=0xAA, b=0xF0 -> 0xA5.
- carry=0 for all four.
REQ-034 The bench SHALL apply SHL a=0xAA, b=0xF5 (n=5) -> out=0x40, carry=1.
REQ-035 The bench SHALL apply SHR a=0x81, b=0x01 -> out=0x40, carry=1.
REQ-036 The bench SHALL assert rst mid-stream with in_valid=1 -> all outputs 0 without a clock edge, and no out_valid after the release.
